// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS core: memory-port arbiter states and port-select values.
package mips_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_BUSY_IF = 2'd1;
  localparam logic [1:0] ARB_BUSY_DM = 2'd2;
  localparam logic [1:0] ARB_RESP    = 2'd3;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_DM = 1'b1;

  typedef enum logic [1:0] {
    StIdle   = ARB_IDLE,
    StBusyIf = ARB_BUSY_IF,
    StBusyDm = ARB_BUSY_DM,
    StResp   = ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/mux_32bit.sv
// Two-input 32-bit word multiplexer; ctrl=1 selects in1.
module mux_32bit (
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic        ctrl,
  output logic [31:0] y
);

  assign y = ctrl ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data memory, one access at a time,
// with a bounded data streak so fetch cannot starve.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        sel,
  output logic        busy
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_e          state_q;
  logic [STREAK_W-1:0] streak_q;
  logic                grant_dm;
  logic [31:0]         grant_addr;

  // Data wins a tie unless fetch has already waited out a full streak.
  assign grant_dm = dm_req && !(if_req && (streak_q == STREAK_MAX));

  mux_32bit u_addr_mux (
    .in0  (if_addr),
    .in1  (dm_addr),
    .ctrl (grant_dm),
    .y    (grant_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      streak_q  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sel       <= SEL_IF;
      busy      <= 1'b0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (if_req || dm_req) begin
            state_q   <= grant_dm ? StBusyDm : StBusyIf;
            sel       <= grant_dm ? SEL_DM : SEL_IF;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            mem_addr  <= grant_addr;
            mem_we    <= grant_dm && dm_we;
            mem_wdata <= grant_dm ? dm_wdata : '0;
            if (grant_dm && if_req) begin
              if (streak_q != STREAK_MAX) begin
                streak_q <= streak_q + STREAK_W'(1);
              end
            end else begin
              streak_q <= '0;
            end
          end
        end
        StBusyIf, StBusyDm: begin
          if (mem_ack) begin
            state_q <= StResp;
            mem_req <= 1'b0;
            if (state_q == StBusyIf) begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end else begin
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
              dm_done <= 1'b1;
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a timeline model predicts every grant and
// completion, and a monitor checks the DUT against the predictions as they appear.
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, dm_done, mem_req, mem_we, sel, busy;

  mem_port_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        is_dm;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    int          cyc;
    logic        is_dm;
    logic [31:0] if_rd;
    logic [31:0] dm_rd;
  } done_t;

  grant_t gq[$];
  done_t  dq[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model state: port timeline, requester history, fetch-starvation streak, rdata registers.
  bit          port_busy = 0;
  bit          cur_dm = 0;
  int          grant_cyc = 0, cur_ack = 0, cur_done = 0, free_at = 0;
  int          if_last = -1, dm_last = -1;
  int          streak = 0;
  logic [31:0] ack_data = '0, if_model = '0, dm_model = '0;
  logic        prev_mem_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus, applied at the negedge of cycle n.
  task automatic step(input bit gen);
    int n = cyc;
    bit gdm;
    if (port_busy && n == cur_done) begin
      if (cur_dm) begin dm_req = 1'b0; dm_last = n; end
      else begin if_req = 1'b0; if_last = n; end
      port_busy = 0;
    end
    if (gen && !if_req && n > if_last && $urandom_range(0, 3) != 0) begin
      if_req  = 1'b1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (gen && !dm_req && n > dm_last && $urandom_range(0, 3) != 0) begin
      dm_req   = 1'b1;
      dm_we    = 1'($urandom_range(0, 1));
      dm_addr  = $urandom;
      dm_wdata = $urandom;
    end
    if (!port_busy && n >= free_at && (if_req || dm_req)) begin
      gdm = dm_req && !(if_req && streak == MAX);
      if (gdm && if_req) streak = (streak < MAX) ? streak + 1 : MAX;
      else streak = 0;
      grant_cyc = n;
      cur_ack   = n + 1 + int'($urandom_range(0, 3));
      cur_done  = cur_ack + 1;
      free_at   = cur_done + 1;
      cur_dm    = gdm;
      port_busy = 1;
      ack_data  = $urandom;
      if (!gdm) if_model = ack_data;
      else if (!dm_we) dm_model = ack_data;
      gq.push_back('{n + 1, gdm, gdm ? dm_addr : if_addr, gdm && dm_we, dm_wdata});
      dq.push_back('{cur_done, gdm, if_model, dm_model});
    end
    if (port_busy && n == cur_ack) begin
      mem_ack = 1'b1; mem_rdata = ack_data;
    end else if (port_busy && n > grant_cyc && n < cur_ack) begin
      mem_ack = 1'b0; mem_rdata = $urandom;
    end else begin
      // Stray acks while idle or responding must be ignored.
      mem_ack = ($urandom_range(0, 3) == 0); mem_rdata = $urandom;
    end
  endtask

  always @(posedge clk) begin
    grant_t g;
    done_t  d;
    #1;
    if (mem_req && !prev_mem_req) begin
      if (gq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_grant: got mem_req=1 expected none (cycle %0d)", cyc);
      end else begin
        g = gq.pop_front();
        chk("grant_cycle", 32'(cyc), 32'(g.cyc));
        chk("grant_sel", 32'(sel), 32'(g.is_dm));
        chk("grant_addr", mem_addr, g.addr);
        chk("grant_we", 32'(mem_we), 32'(g.we));
        if (g.is_dm) chk("grant_wdata", mem_wdata, g.wdata);
        chk("grant_busy", 32'(busy), 32'd1);
      end
    end
    if (if_done || dm_done) begin
      if (dq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_done: got if_done=%b dm_done=%b expected none (cycle %0d)",
                 if_done, dm_done, cyc);
      end else begin
        d = dq.pop_front();
        chk("done_cycle", 32'(cyc), 32'(d.cyc));
        chk("done_which", 32'({if_done, dm_done}), d.is_dm ? 32'd1 : 32'd2);
        chk("if_rdata", if_rdata, d.if_rd);
        chk("dm_rdata", dm_rdata, d.dm_rd);
        chk("done_mem_req", 32'(mem_req), 32'd0);
      end
    end
    prev_mem_req = mem_req;
  end

  initial begin
    int k;
    rst_n = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dones", 32'({if_done, dm_done}), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      step(1'b1);
    end
    k = 0;
    while ((port_busy || if_req || dm_req || gq.size() != 0 || dq.size() != 0) && k < 200) begin
      @(negedge clk);
      step(1'b0);
      k++;
    end
    if (k >= 200) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d pending expected 0", gq.size() + dq.size());
    end
    chk("drain_queues_empty", 32'(gq.size() + dq.size()), 32'd0);

    // Reset in the middle of a data load: access abandoned, no completion.
    @(negedge clk); mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0008; dm_wdata = 32'h0BAD_F00D;
    gq.push_back('{cyc + 1, 1'b1, dm_addr, 1'b0, dm_wdata});
    repeat (3) @(negedge clk);
    chk("mid_access_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0; dm_req = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_dm_rdata", dm_rdata, 32'd0);
    chk("post_rst_if_rdata", if_rdata, 32'd0);
    chk("post_rst_queues", 32'(gq.size() + dq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
